// File: rtl/text_buf_pkg.sv
// rtl/text_buf_pkg.sv - character codes, controller states and byte classification for the text buffer
package text_buf_pkg;

    localparam logic [7:0] CHR_SPACE = 8'h20;
    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_DEL   = 8'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SCROLL = 2'd2
    } state_t;

    // Glyph-bearing codes: ASCII 0x20-0x7E, plus every code with bit 7 set (Thai set)
    function automatic logic is_printable(input logic [7:0] b);
        return b[7] || ((b >= CHR_SPACE) && (b < CHR_DEL));
    endfunction

endpackage

// File: rtl/text_cell_mem.sv
// rtl/text_cell_mem.sv - unreset character cell array, one write port and two combinational read ports
module text_cell_mem
    import text_buf_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = 7
)(
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [7:0]    o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [7:0]    o_rdata_b
);

    logic [7:0] r_mem [DEPTH];

    // Single write port; contents are initialised by the controller's CLEAR sweep, not by reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/text_char_buffer.sv
// rtl/text_char_buffer.sv - text window memory: byte-stream decoder, clear/scroll sweeps and scan-position readout
module text_char_buffer
    import text_buf_pkg::*;
#(
    parameter int COLS = 32,
    parameter int ROWS = 4,
    parameter int X0   = 192,
    parameter int Y0   = 208
)(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    output logic [7:0]              ascii_code,
    output logic [$clog2(COLS)-1:0] cursor_col,
    output logic [$clog2(ROWS)-1:0] cursor_row,
    output logic                    busy
);

    localparam int CW       = $clog2(COLS);
    localparam int RW       = $clog2(ROWS);
    localparam int AW       = CW + RW;
    localparam int DEPTH    = COLS * ROWS;
    localparam int COPY_LEN = COLS * (ROWS - 1);

    localparam logic [9:0] X_LO = 10'(X0);
    localparam logic [9:0] X_HI = 10'(X0 + 8 * COLS);
    localparam logic [9:0] Y_LO = 10'(Y0);
    localparam logic [9:0] Y_HI = 10'(Y0 + 16 * ROWS);

    state_t        r_state;
    logic [AW-1:0] r_idx;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [7:0]    r_ascii;

    logic          w_accept;
    logic          w_printable;
    logic          w_newline;
    logic          w_last_col;
    logic          w_last_row;
    logic          w_sweep_done;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [7:0]    w_wdata;
    logic [AW-1:0] w_scroll_raddr;
    logic [7:0]    w_scroll_rdata;
    logic [AW-1:0] w_disp_raddr;
    logic [7:0]    w_disp_rdata;
    logic          w_in_win;
    logic [9:0]    w_dx;
    logic [9:0]    w_dy;

    assign in_ready     = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign w_accept     = in_valid && in_ready;
    assign w_printable  = is_printable(in_data);
    assign w_last_col   = (r_col == CW'(COLS - 1));
    assign w_last_row   = (r_row == RW'(ROWS - 1));
    assign w_sweep_done = (r_idx == AW'(DEPTH - 1));
    // A wrap off the last column behaves exactly like CR/LF
    assign w_newline    = w_accept && ((w_printable && w_last_col) ||
                                       (in_data == CHR_LF) || (in_data == CHR_CR));

    // The scroll sweep reads one row ahead of the cell it rewrites
    assign w_scroll_raddr = r_idx + AW'(COLS);

    // Cell write selection: sweeps own the port while busy, decoded bytes while idle
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_idx;
        w_wdata = CHR_SPACE;
        case (r_state)
            CLEAR: begin
                w_we = 1'b1;
            end
            SCROLL: begin
                w_we = 1'b1;
                if (r_idx < AW'(COPY_LEN)) begin
                    w_wdata = w_scroll_rdata;
                end
            end
            default: begin
                if (w_accept && w_printable) begin
                    w_we    = 1'b1;
                    w_waddr = {r_row, r_col};
                    w_wdata = in_data;
                end else if (w_accept && (in_data == CHR_BS) && (r_col != '0)) begin
                    w_we    = 1'b1;
                    w_waddr = {r_row, r_col - CW'(1)};
                end
            end
        endcase
    end

    // Controller state, sweep index and cursor
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CLEAR;
            r_idx   <= '0;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            case (r_state)
                CLEAR, SCROLL: begin
                    r_idx <= r_idx + AW'(1);
                    if (w_sweep_done) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    if (w_newline) begin
                        r_col <= '0;
                        if (w_last_row) begin
                            r_state <= SCROLL;
                            r_idx   <= '0;
                        end else begin
                            r_row <= r_row + RW'(1);
                        end
                    end else if (w_accept && w_printable) begin
                        r_col <= r_col + CW'(1);
                    end else if (w_accept && (in_data == CHR_BS) && (r_col != '0)) begin
                        r_col <= r_col - CW'(1);
                    end else if (w_accept && (in_data == CHR_FF)) begin
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= CLEAR;
                        r_idx   <= '0;
                    end
                end
            endcase
        end
    end

    assign w_in_win     = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
    assign w_dx         = x - X_LO;
    assign w_dy         = y - Y_LO;
    assign w_disp_raddr = {RW'(w_dy >> 4), CW'(w_dx >> 3)};

    // Registered display lookup; a same-clock write is seen one clock later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ascii <= CHR_SPACE;
        end else begin
            r_ascii <= w_in_win ? w_disp_rdata : CHR_SPACE;
        end
    end

    assign ascii_code = r_ascii;
    assign cursor_col = r_col;
    assign cursor_row = r_row;

    text_cell_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_cells (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (w_scroll_raddr),
        .o_rdata_a (w_scroll_rdata),
        .i_raddr_b (w_disp_raddr),
        .o_rdata_b (w_disp_rdata)
    );

endmodule

// File: tb/tb_text_char_buffer.sv
// tb/tb_text_char_buffer.sv - scoreboard bench for text_char_buffer against a cell-array reference model
module tb_text_char_buffer;

    localparam int COLS  = 32;
    localparam int ROWS  = 4;
    localparam int X0    = 192;
    localparam int Y0    = 208;
    localparam int NCELL = COLS * ROWS;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] x        = '0;
    logic [9:0] y        = '0;
    logic [7:0] ascii_code;
    logic [4:0] cursor_col;
    logic [1:0] cursor_row;
    logic       busy;

    always #5 clk = ~clk;

    text_char_buffer #(
        .COLS (COLS),
        .ROWS (ROWS),
        .X0   (X0),
        .Y0   (Y0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .ascii_code (ascii_code),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] code;
        int         px;
        int         py;
    } probe_t;

    probe_t     exp_q[$];
    logic       probe_v = 1'b0;
    int         checks  = 0;
    int         errors  = 0;
    logic [7:0] m_cells [NCELL];
    int         m_col   = 0;
    int         m_row   = 0;

    function automatic void m_blank();
        for (int i = 0; i < NCELL; i++) m_cells[i] = 8'h20;
    endfunction

    // Returns 1 when the newline pushes text up a row
    function automatic int m_newline();
        if (m_row < ROWS - 1) begin
            m_row++;
            return 0;
        end
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++)
                m_cells[r * COLS + c] = m_cells[(r + 1) * COLS + c];
        for (int c = 0; c < COLS; c++) m_cells[(ROWS - 1) * COLS + c] = 8'h20;
        return 1;
    endfunction

    // Applies one byte; returns 1 when the buffer goes busy for a sweep
    function automatic int m_byte(input logic [7:0] b);
        int op = 0;
        if (b[7] || (b >= 8'h20 && b <= 8'h7E)) begin
            m_cells[m_row * COLS + m_col] = b;
            if (m_col == COLS - 1) begin
                m_col = 0;
                op = m_newline();
            end else begin
                m_col++;
            end
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_cells[m_row * COLS + m_col] = 8'h20;
            end
        end else if (b == 8'h0A || b == 8'h0D) begin
            m_col = 0;
            op = m_newline();
        end else if (b == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            m_blank();
            op = 1;
        end
        return op;
    endfunction

    function automatic logic [7:0] exp_at(input int px, input int py);
        if (px >= X0 && px < X0 + 8 * COLS && py >= Y0 && py < Y0 + 16 * ROWS)
            return m_cells[((py - Y0) / 16) * COLS + (px - X0) / 8];
        return 8'h20;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic probe(input int px, input int py);
        probe_t p;
        p.code = exp_at(px, py);
        p.px   = px;
        p.py   = py;
        exp_q.push_back(p);
        x       = 10'(px);
        y       = 10'(py);
        probe_v = 1'b1;
        @(posedge clk); #1;
        probe_v = 1'b0;
    endtask

    task automatic probe_cell(input int c);
        probe(X0 + (c % COLS) * 8 + int'($urandom_range(7)), Y0 + (c / COLS) * 16 + int'($urandom_range(15)));
    endtask

    task automatic check_all_cells();
        for (int i = 0; i < NCELL; i++) probe_cell(i);
    endtask

    // Offers a junk byte while busy; it must be ignored
    task automatic wait_ready(input string name, input int exp_n);
        int n = 0;
        chk({name, "_busy_high"}, busy, 1);
        in_data  = 8'h5A;
        in_valid = 1'b1;
        while (!in_ready && n < 1000) begin
            n++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk(name, n, exp_n);
        chk({name, "_busy_low"}, busy, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit wait_busy);
        int op;
        chk("in_ready_before_send", in_ready, 1);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = m_byte(b);
        chk("cursor_col", cursor_col, m_col);
        chk("cursor_row", cursor_row, m_row);
        chk("busy_after_byte", busy, op);
        if (op != 0 && wait_busy) wait_ready("sweep_len", 128);
    endtask

    function automatic logic [7:0] rand_byte();
        int r = int'($urandom_range(99));
        logic [7:0] b;
        if (r < 55)      b = 8'(32 + $urandom_range(94));
        else if (r < 70) b = 8'(128 + $urandom_range(127));
        else if (r < 80) b = 8'h08;
        else if (r < 88) b = ($urandom_range(1) != 0) ? 8'h0A : 8'h0D;
        else if (r < 97) begin
            b = 8'($urandom_range(31));
            if (b == 8'h08 || b == 8'h0A || b == 8'h0D || b == 8'h0C) b = 8'h7F;
        end else         b = 8'h0C;
        return b;
    endfunction

    // Scoreboard monitor: one registered result per probe, compared on the falling edge
    initial begin
        probe_t p;
        logic   took;
        forever begin
            @(posedge clk);
            took = probe_v;
            @(negedge clk);
            if (took) begin
                if (exp_q.size() == 0) begin
                    chk("ascii_code_unexpected_probe", 1, 0);
                end else begin
                    p = exp_q.pop_front();
                    chk($sformatf("ascii_code@(%0d,%0d)", p.px, p.py), ascii_code, p.code);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ascii", ascii_code, 8'h20);
        chk("rst_cursor_col", cursor_col, 0);
        chk("rst_cursor_row", cursor_row, 0);
        reset_n = 1'b1;
        m_blank();
        wait_ready("reset_clear_len", 128);
        probe(192, 208);

        send_byte(8'h41, 1);
        for (int i = 0; i < 8; i++) probe(192 + i, 208 + int'($urandom_range(15)));
        probe(200, 208);
        probe(100, 208);
        probe(191, 208);
        probe(192, 207);
        probe(448, 208);
        probe(192, 272);
        probe(447, 271);

        send_byte(8'h0C, 1);
        send_byte(8'h41, 1);
        send_byte(8'h42, 1);
        send_byte(8'h08, 1);
        probe_cell(0);
        probe_cell(1);
        send_byte(8'h08, 1);
        send_byte(8'h08, 1);
        chk("bs_col0_in_ready", in_ready, 1);
        probe_cell(0);

        send_byte(8'h0C, 1);
        for (int i = 0; i < 128; i++) send_byte(8'(8'h30 + i % 10), 1);
        check_all_cells();
        send_byte(8'hA1, 1);
        probe_cell(96);
        probe_cell(97);

        send_byte(8'h58, 1);
        send_byte(8'h59, 1);
        send_byte(8'h0C, 1);
        check_all_cells();
        send_byte(8'h0D, 1);
        send_byte(8'h0D, 1);
        chk("cr_no_scroll_in_ready", in_ready, 1);

        for (int i = 0; i < 400; i++) send_byte(rand_byte(), 1);
        check_all_cells();
        for (int i = 0; i < 6; i++) begin
            probe(int'($urandom_range(X0 - 1)), int'($urandom_range(524)));
            probe(X0 + 8 * COLS + int'($urandom_range(799 - X0 - 8 * COLS)), int'($urandom_range(524)));
            probe(int'($urandom_range(799)), int'($urandom_range(Y0 - 1)));
            probe(int'($urandom_range(799)), Y0 + 16 * ROWS + int'($urandom_range(524 - Y0 - 16 * ROWS)));
        end

        send_byte(8'h0C, 1);
        send_byte(8'h0A, 1);
        send_byte(8'h0A, 1);
        send_byte(8'h0A, 1);
        send_byte(8'h4B, 1);
        send_byte(8'h0A, 0);
        repeat (50) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midscroll_rst_in_ready", in_ready, 0);
        chk("midscroll_rst_busy", busy, 1);
        chk("midscroll_rst_cursor_row", cursor_row, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_blank();
        m_col = 0;
        m_row = 0;
        wait_ready("midscroll_reclear_len", 128);
        chk("midscroll_cursor_col", cursor_col, 0);
        chk("midscroll_cursor_row", cursor_row, 0);
        check_all_cells();

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/text_char_buffer.md
Name: text_char_buffer

Overview:
- Screen-side text memory that feeds the glyph renderer's `ascii_code` input.
- Accepts a byte stream (keyboard/UART decoder) over a valid/ready handshake and interprets printable and control codes.
- Stores characters in a COLS x ROWS cell array and returns, each clock, the code of the cell under the current VGA scan position.
- Covers the 256x64-pixel text window at (192,208) with 8x16 glyphs; bit 7 of a stored code selects the Thai glyph set and is stored verbatim.

Parameters:
- COLS, 32, characters per row (power of two).
- ROWS, 4, text rows (power of two).
- X0, 192, pixel x of window left edge.
- Y0, 208, pixel y of window top edge.

Ports:
- clk  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  incoming character or control code.
- in_valid  in  1  in_data valid.
- in_ready  out  1  buffer can accept a byte this cycle.
- x  in  10  current pixel column from the VGA controller.
- y  in  10  current pixel row from the VGA controller.
- ascii_code  out  8  code of the cell under (x,y); 0x20 outside the window.
- cursor_col  out  $clog2(COLS)  next write column.
- cursor_row  out  $clog2(ROWS)  next write row.
- busy  out  1  high during CLEAR or SCROLL.

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset (async assert):
  - state=CLEAR, sweep index=0, cursor=(0,0), in_ready=0, busy=1, ascii_code=0x20.
  - Cell storage is not reset; CLEAR initialises it.
- States:
  - IDLE: in_ready=1. A byte is accepted when in_valid && in_ready, and is processed in that same cycle.
  - CLEAR: writes 0x20 to cell[idx], idx 0..COLS*ROWS-1, one cell per clock (128 clocks by default), then goes to IDLE. Cursor is (0,0).
  - SCROLL: copy phase runs cell[i] <= cell[i+COLS] for i=0..COLS*(ROWS-1)-1 (96 clocks). Blank phase then writes 0x20 to the last row (32 clocks), then goes to IDLE. Total 128 clocks; cursor stays (ROWS-1,0).
- Byte decode in IDLE, with bit7=0 codes first:
  - 0x08 BS: if col>0, col-1 and write 0x20 at the new position. At col 0 it is a no-op; no wrap to the previous row.
  - 0x0A or 0x0D: col=0. If row<ROWS-1, row+1; else enter SCROLL.
  - 0x0C: cursor=(0,0), enter CLEAR.
  - Other 0x00-0x1F and 0x7F: accepted and ignored.
  - 0x20-0x7E and any byte with bit7=1: write to cell[row*COLS+col], then advance col.
    - If col was COLS-1: col=0 and apply the newline rule; row ROWS-1 enters SCROLL after the write.
- Throughput: printable bytes are accepted 1 per clock until a wrap or newline triggers SCROLL.
- in_ready is low for the full CLEAR/SCROLL duration. in_data is ignored while in_ready=0.
- Display read:
  - Window test: X0<=x<X0+8*COLS and Y0<=y<Y0+16*ROWS.
  - Cell index: col=(x-X0)>>3, row=(y-Y0)>>4.
  - ascii_code is registered with latency 1 clk from x,y. It returns the cell contents, including cells being changed during CLEAR/SCROLL; transient artefacts are accepted.
  - Outside the window, ascii_code=0x20.
- Simultaneous events: a display read of a cell written in the same clock returns the old value and updates the next clock.
- Reset mid-CLEAR/SCROLL aborts the operation and restarts CLEAR from idx 0.

Decomposition:
- Package text_buf_pkg holds:
  - Constants CHR_SPACE=8'h20, CHR_BS=8'h08, CHR_LF=8'h0A, CHR_CR=8'h0D, CHR_FF=8'h0C, CHR_DEL=8'h7F.
  - State enum {IDLE, CLEAR, SCROLL}.
  - Function is_printable(byte).
- Sub-module text_cell_mem: COLS*ROWS x 8 register array with one write port and two asynchronous read ports (scroll source, display). Not reset.

Test Plan:
- Reset release -> in_ready=0 for 128 clocks then 1. With x=192,y=208, ascii_code=0x20; cursor=(0,0).
- Send 0x41 -> cursor_col=1. One clock after x=192..199,y=208..223, ascii_code=0x41; x=200,y=208 -> 0x20; x=100 -> 0x20.
- Send "AB", 0x08 -> cursor_col=1, cell1=0x20, cell0=0x41. 0x08 at col 0 -> no change, in_ready stays 1.
- Send 128 bytes 0x30+(i%10), then probe busy/in_ready and send byte 129 = 0xA1:
  - Last byte -> busy=1, in_ready=0 for 128 clocks.
  - Afterwards row0 holds former row1, row3 is all 0x20, cursor=(3,0).
  - Byte 129 (0xA1) is stored at cell 96 with bit7 intact.
- Send "XY", 0x0C -> 128-clock CLEAR, all cells 0x20, cursor=(0,0). 0x0D on row 1 -> cursor=(2,0) with no scroll.
- Assert reset_n low at SCROLL clock 50 -> in_ready=0 immediately; after release, full 128-clock CLEAR, all 0x20.
